// File: rtl/lc3_mem_if.sv
// lc3_mem_if: owns MAR/MDR and sequences fixed-wait-state accesses to an
// asynchronous-read SRAM, returning a one-cycle READY pulse to the LC-3 FSM.
module lc3_mem_if #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              CS,
  input  logic              WE,
  input  logic [DATA_W-1:0] BUS,
  output logic [ADDR_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic              READY,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  generate
    if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("lc3_mem_if: WAIT_STATES must lie in 1..15");
    end
    if (ADDR_W > DATA_W) begin : g_bad_widths
      $error("lc3_mem_if: ADDR_W must not exceed DATA_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;

  // mem_addr/mem_wdata double as the latched address and write data of the
  // in-flight access, so later MAR/MDR loads cannot disturb it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      READY     <= 1'b0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          READY <= 1'b0;
          if (CS) begin
            state     <= ACCESS;
            cnt       <= 4'(WAIT_STATES - 1);
            we_q      <= WE;
            busy      <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= WE;
            mem_addr  <= MAR;
            mem_wdata <= MDR;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!we_q) rdata_q <= mem_rdata;
            state  <= DONE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            READY  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          READY <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          READY  <= 1'b0;
          busy   <= 1'b0;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // A bus load of MDR (CS low) takes priority over returning read data.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MAR <= '0;
      MDR <= '0;
    end else begin
      if (LD_MAR) MAR <= BUS[ADDR_W-1:0];
      if (LD_MDR && !CS)                         MDR <= BUS;
      else if (LD_MDR && state == DONE && !we_q) MDR <= rdata_q;
    end
  end

endmodule

// File: tb/tb_lc3_mem_if.sv
// tb_lc3_mem_if: randomized self-checking bench for lc3_mem_if against a
// cycle-indexed access model and a bench-side memory image.
module tb_lc3_mem_if;

  localparam int WS = 2;

  logic        CLK = 1'b0;
  logic        RESET, LD_MAR, LD_MDR, CS, CS1, WE;
  logic [15:0] BUS;

  logic [15:0] MAR, MDR, mem_addr, mem_wdata, mem_rdata;
  logic        READY, busy, mem_en, mem_we;
  logic [15:0] MAR1, MDR1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        READY1, busy1, mem_en1, mem_we1;

  logic [15:0] sram [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr, pl_data;

  int checks = 0;
  int errors = 0;
  logic [15:0] model_mem [int];
  logic [15:0] model_mdr, model_mar;

  lc3_mem_if #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(WS)) u_dut (
    .CLK(CLK), .RESET(RESET), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .CS(CS), .WE(WE),
    .BUS(BUS), .MAR(MAR), .MDR(MDR), .READY(READY), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  lc3_mem_if #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(1)) u_dut_ws1 (
    .CLK(CLK), .RESET(RESET), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .CS(CS1), .WE(WE),
    .BUS(BUS), .MAR(MAR1), .MDR(MDR1), .READY(READY1), .busy(busy1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  always #5 CLK = ~CLK;

  assign mem_rdata  = sram[mem_addr];
  assign mem_rdata1 = sram[mem_addr1];

  always @(posedge CLK) begin
    if (pl_en) sram[pl_addr] <= pl_data;
    if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_en1 && mem_we1) sram[mem_addr1] <= mem_wdata1;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic load_mar(input logic [15:0] a);
    BUS = a; LD_MAR = 1'b1;
    tick();
    LD_MAR = 1'b0;
    model_mar = a;
  endtask

  task automatic test_reset;
    RESET = 1'b1; CS = 1'b0; CS1 = 1'b0; WE = 1'b0; LD_MAR = 1'b0; LD_MDR = 1'b0;
    BUS = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    tick(); tick();
    checks++;
    if ({READY, busy, mem_en, mem_we} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctl: rdy/busy/en/we=%b required 0000", {READY, busy, mem_en, mem_we});
    end
    checks++;
    if (MAR !== 16'h0 || MDR !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      errors++; $display("FAIL reset_regs: MAR=%h MDR=%h addr=%h wdata=%h required all 0", MAR, MDR, mem_addr, mem_wdata);
    end
    RESET = 1'b0;
    model_mdr = '0; model_mar = '0;
    tick();
  endtask

  task automatic test_read(input logic [15:0] a, input logic [15:0] d, input bit pre);
    logic [15:0] exp;
    if (pre) preload(a, d);
    exp = model_mem[a];
    load_mar(a);
    BUS = 16'($urandom); CS = 1'b1; WE = 1'b0; LD_MDR = 1'b1;
    for (int c = 0; c <= WS + 1; c++) begin
      checks++;
      if (mem_en !== 1'(c >= 1 && c <= WS) || READY !== 1'(c == WS + 1) || busy !== 1'(c >= 1)) begin
        errors++; $display("FAIL rd_ctl c=%0d: en=%b rdy=%b busy=%b required %b %b %b", c, mem_en, READY, busy,
                           1'(c >= 1 && c <= WS), 1'(c == WS + 1), 1'(c >= 1));
      end
      if (c >= 1 && c <= WS) begin
        checks++;
        if (mem_addr !== a || mem_we !== 1'b0) begin
          errors++; $display("FAIL rd_bus c=%0d: addr=%h we=%b required %h 0", c, mem_addr, mem_we, a);
        end
      end
      checks++;
      if (MDR !== model_mdr) begin
        errors++; $display("FAIL rd_mdr_hold c=%0d: MDR=%h required %h", c, MDR, model_mdr);
      end
      tick();
    end
    CS = 1'b0; LD_MDR = 1'b0;
    model_mdr = exp;
    checks++;
    if (MDR !== exp || MAR !== a) begin
      errors++; $display("FAIL rd_data: MDR=%h MAR=%h required %h %h", MDR, MAR, exp, a);
    end
    tick();
  endtask

  task automatic test_write(input logic [15:0] a, input logic [15:0] d);
    load_mar(a);
    BUS = d; LD_MDR = 1'b1; CS = 1'b0;
    tick();
    LD_MDR = 1'b0; model_mdr = d;
    checks++;
    if (MDR !== d) begin
      errors++; $display("FAIL wr_mdr_load: MDR=%h required %h", MDR, d);
    end
    BUS = 16'($urandom); CS = 1'b1; WE = 1'b1;
    for (int c = 0; c <= WS + 1; c++) begin
      checks++;
      if (mem_en !== 1'(c >= 1 && c <= WS) || mem_we !== 1'(c >= 1 && c <= WS) || READY !== 1'(c == WS + 1)) begin
        errors++; $display("FAIL wr_ctl c=%0d: en=%b we=%b rdy=%b", c, mem_en, mem_we, READY);
      end
      if (c >= 1 && c <= WS) begin
        checks++;
        if (mem_addr !== a || mem_wdata !== d) begin
          errors++; $display("FAIL wr_bus c=%0d: addr=%h wdata=%h required %h %h", c, mem_addr, mem_wdata, a, d);
        end
      end
      // Dropping CS and flipping WE mid-access must not disturb the write.
      if (c == 1) begin CS = 1'b0; WE = 1'b0; end
      tick();
    end
    model_mem[a] = d;
    checks++;
    if (MDR !== d) begin
      errors++; $display("FAIL wr_mdr_keep: MDR=%h required %h", MDR, d);
    end
    tick();
  endtask

  task automatic test_bus_load;
    logic [15:0] v;
    for (int i = 0; i < 3; i++) begin
      v = (i == 0) ? 16'h5A5A : 16'($urandom);
      BUS = v; LD_MDR = 1'b1; CS = 1'b0;
      tick();
      LD_MDR = 1'b0; model_mdr = v;
      checks++;
      if (MDR !== v || mem_en !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL bus_load: MDR=%h en=%b busy=%b required %h 0 0", MDR, mem_en, busy, v);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] a;
    a = 16'($urandom);
    preload(a, 16'($urandom));
    load_mar(a);
    CS = 1'b1; WE = 1'b0; LD_MDR = 1'b1;
    tick(); tick();
    checks++;
    if (mem_en !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: en=%b required 1", mem_en);
    end
    RESET = 1'b1;
    #1;
    checks++;
    if ({mem_en, mem_we, busy, READY} !== 4'b0000 || MDR !== 16'h0 || MAR !== 16'h0) begin
      errors++; $display("FAIL rst_mid_async: en/we/busy/rdy=%b MDR=%h MAR=%h required 0000 0 0",
                         {mem_en, mem_we, busy, READY}, MDR, MAR);
    end
    CS = 1'b0; LD_MDR = 1'b0; model_mdr = '0; model_mar = '0;
    tick();
    RESET = 1'b0;
    for (int c = 0; c <= WS + 3; c++) begin
      checks++;
      if (READY !== 1'b0 || mem_en !== 1'b0) begin
        errors++; $display("FAIL rst_mid_quiet c=%0d: rdy=%b en=%b required 0 0", c, READY, mem_en);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic exp_en, exp_rdy;
    logic [15:0] exp_addr, exp_mdr;
    preload(16'h0010, 16'h1111);
    preload(16'h0011, 16'h2222);
    load_mar(16'h0010);
    CS = 1'b1; WE = 1'b0; LD_MDR = 1'b1; BUS = 16'($urandom);
    for (int c = 0; c <= 2 * WS + 3; c++) begin
      exp_en   = (c >= 1 && c <= WS) || (c >= WS + 3 && c <= 2 * WS + 2);
      exp_rdy  = (c == WS + 1) || (c == 2 * WS + 3);
      exp_addr = (c <= WS) ? 16'h0010 : 16'h0011;
      exp_mdr  = (c <= WS + 1) ? model_mdr : 16'h1111;
      checks++;
      if (mem_en !== exp_en || READY !== exp_rdy || busy !== (exp_en | exp_rdy)) begin
        errors++; $display("FAIL b2b_ctl c=%0d: en=%b rdy=%b busy=%b required %b %b %b", c, mem_en, READY, busy,
                           exp_en, exp_rdy, exp_en | exp_rdy);
      end
      if (exp_en) begin
        checks++;
        if (mem_addr !== exp_addr) begin
          errors++; $display("FAIL b2b_addr c=%0d: addr=%h required %h", c, mem_addr, exp_addr);
        end
      end
      checks++;
      if (MDR !== exp_mdr) begin
        errors++; $display("FAIL b2b_mdr c=%0d: MDR=%h required %h", c, MDR, exp_mdr);
      end
      if (c == 1) begin LD_MAR = 1'b1; BUS = 16'h0011; end
      else LD_MAR = 1'b0;
      tick();
    end
    CS = 1'b0; LD_MDR = 1'b0;
    model_mdr = 16'h2222; model_mar = 16'h0011;
    checks++;
    if (MDR !== 16'h2222 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_final: MDR=%h busy=%b required 2222 0", MDR, busy);
    end
    tick();
  endtask

  task automatic test_random;
    logic [15:0] pool [8];
    logic [15:0] base, addr, wdata;
    logic        wr, exp_act;
    base = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      pool[i] = base + 16'(i);
      preload(pool[i], 16'($urandom));
    end
    for (int n = 0; n < 30; n++) begin
      CS = 1'b0; LD_MDR = 1'b0; WE = 1'b0;
      load_mar(pool[$urandom_range(0, 7)]);
      wr = 1'($urandom_range(0, 1));
      if (wr) begin
        BUS = 16'($urandom); LD_MDR = 1'b1;
        tick();
        model_mdr = BUS; LD_MDR = 1'b0;
      end
      CS = 1'b1; WE = wr; LD_MDR = 1'($urandom); LD_MAR = 1'($urandom); BUS = 16'($urandom);
      addr = model_mar; wdata = model_mdr;
      for (int c = 0; c <= WS + 1; c++) begin
        exp_act = (c >= 1 && c <= WS);
        checks++;
        if (mem_en !== exp_act || mem_we !== (exp_act & wr) || READY !== 1'(c == WS + 1)) begin
          errors++; $display("FAIL rnd_ctl n=%0d c=%0d: en=%b we=%b rdy=%b", n, c, mem_en, mem_we, READY);
        end
        if (exp_act) begin
          checks++;
          if (mem_addr !== addr || (wr && mem_wdata !== wdata)) begin
            errors++; $display("FAIL rnd_bus n=%0d c=%0d: addr=%h wdata=%h required %h %h", n, c, mem_addr, mem_wdata, addr, wdata);
          end
        end
        checks++;
        if (MDR !== model_mdr || MAR !== model_mar) begin
          errors++; $display("FAIL rnd_regs n=%0d c=%0d: MDR=%h MAR=%h required %h %h", n, c, MDR, MAR, model_mdr, model_mar);
        end
        if (LD_MAR) model_mar = BUS;
        if (LD_MDR && !CS) model_mdr = BUS;
        else if (LD_MDR && c == WS + 1 && !wr) model_mdr = model_mem[addr];
        tick();
        if (c + 1 <= WS + 1) begin
          CS = 1'($urandom); WE = 1'($urandom); LD_MDR = 1'($urandom);
          LD_MAR = 1'($urandom); BUS = 16'($urandom);
        end
      end
      if (wr) model_mem[addr] = wdata;
      CS = 1'b0; LD_MDR = 1'b0; LD_MAR = 1'b0; WE = 1'b0;
      checks++;
      if (MDR !== model_mdr || MAR !== model_mar || busy !== 1'b0) begin
        errors++; $display("FAIL rnd_end n=%0d: MDR=%h MAR=%h busy=%b required %h %h 0", n, MDR, MAR, busy, model_mdr, model_mar);
      end
    end
    tick();
  endtask

  task automatic test_ws1;
    logic [15:0] a, d;
    a = 16'($urandom); d = 16'($urandom);
    preload(a, d);
    load_mar(a);
    CS1 = 1'b1; WE = 1'b0; LD_MDR = 1'b0;
    checks++;
    if (mem_en1 !== 1'b0 || READY1 !== 1'b0 || MAR1 !== a) begin
      errors++; $display("FAIL ws1_c0: en=%b rdy=%b MAR=%h required 0 0 %h", mem_en1, READY1, MAR1, a);
    end
    tick();
    CS1 = 1'b0;
    checks++;
    if (mem_en1 !== 1'b1 || mem_addr1 !== a || READY1 !== 1'b0) begin
      errors++; $display("FAIL ws1_c1: en=%b addr=%h rdy=%b required 1 %h 0", mem_en1, mem_addr1, READY1, a);
    end
    tick();
    // Overwrite the word after capture; MDR must still receive the old value.
    pl_en = 1'b1; pl_addr = a; pl_data = ~d;
    CS1 = 1'b1; LD_MDR = 1'b1;
    checks++;
    if (READY1 !== 1'b1 || mem_en1 !== 1'b0) begin
      errors++; $display("FAIL ws1_c2: rdy=%b en=%b required 1 0", READY1, mem_en1);
    end
    tick();
    pl_en = 1'b0; CS1 = 1'b0; LD_MDR = 1'b0;
    checks++;
    if (READY1 !== 1'b0 || MDR1 !== d || busy1 !== 1'b0) begin
      errors++; $display("FAIL ws1_c3: rdy=%b MDR=%h busy=%b required 0 %h 0", READY1, MDR1, busy1, d);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_read(16'h3000, 16'hABCD, 1'b1);
    test_write(16'h4000, 16'h1234);
    test_read(16'h4000, 16'h0000, 1'b0);
    test_bus_load();
    test_reset_mid();
    test_read(16'($urandom), 16'($urandom), 1'b1);
    test_back_to_back();
    test_random();
    test_ws1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
